// File: rtl/gpio_pad_pkg.sv
// ============================================================================
// Module  : gpio_pad_pkg
// Brief   : Shared encodings for the sky130 GPIO pad sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package gpio_pad_pkg;

  // Drive-mode encodings for the pad DM[2:0] pins
  localparam logic [2:0] DM_INPUT  = 3'b001;
  localparam logic [2:0] DM_PULLUP = 3'b010;
  localparam logic [2:0] DM_STRONG = 3'b110;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  typedef enum logic [2:0] {
    PWRUP    = 3'd0,
    RELEASE  = 3'd1,
    IDLE_IN  = 3'd2,
    IDLE_OUT = 3'd3,
    TURN     = 3'd4,
    HOLD     = 3'd5
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/gpio_seq_timer.sv
// ============================================================================
// Module  : gpio_seq_timer
// Brief   : Loadable saturating down-counter with a zero/done flag.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_seq_timer #(
  parameter int              CNT_W   = 5,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/gpio_pad_seq_ctrl.sv
// ============================================================================
// Module  : gpio_pad_seq_ctrl
// Brief   : Power-up, break-before-make direction and hold sequencer for one
//           sky130 bidirectional GPIO pad. GPIO_PAD_SEQ_PULL_EN selects a
//           pull-up drive mode for the idle input state.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_pad_seq_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int PWRUP_CYC = 16,
  parameter int DEAD_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir_req,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       hold_req,
  output logic       hold_ack,
  output logic       cur_dir,
  output logic       busy,
  output logic       pad_enable_h,
  output logic       pad_hld_h_n,
  output logic       pad_oe_n,
  output logic       pad_inp_dis,
  output logic [2:0] pad_dm
);

  localparam int CNT_W = $clog2(((PWRUP_CYC > DEAD_CYC) ? PWRUP_CYC : DEAD_CYC) + 1);

`ifdef GPIO_PAD_SEQ_PULL_EN
  localparam logic [2:0] DM_IDLE_IN = DM_PULLUP;
`else
  localparam logic [2:0] DM_IDLE_IN = DM_INPUT;
`endif

  seq_state_e state_q, state_d;
  logic       enable_h_q, enable_h_d;
  logic       hld_h_n_q, hld_h_n_d;
  logic       oe_n_q, oe_n_d;
  logic       inp_dis_q, inp_dis_d;
  logic [2:0] dm_q, dm_d;
  logic       cur_dir_q, cur_dir_d;
  logic       req_ready_q, req_ready_d;
  logic       hold_ack_q, hold_ack_d;
  logic       busy_q, busy_d;
  logic       dir_lat_q, dir_lat_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             go_idle;
  logic             tgt_dir;

  // The reset cycle itself is not counted, so PWRUP_CYC is the reload value.
  gpio_seq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(PWRUP_CYC))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    enable_h_d  = enable_h_q;
    hld_h_n_d   = hld_h_n_q;
    oe_n_d      = oe_n_q;
    inp_dis_d   = inp_dis_q;
    dm_d        = dm_q;
    cur_dir_d   = cur_dir_q;
    req_ready_d = req_ready_q;
    hold_ack_d  = hold_ack_q;
    busy_d      = busy_q;
    dir_lat_d   = dir_lat_q;
    tmr_load    = 1'b0;
    tmr_val     = CNT_W'(DEAD_CYC - 1);
    go_idle     = 1'b0;
    tgt_dir     = DIR_IN;

    case (state_q)
      PWRUP: begin
        enable_h_d = 1'b1;
        if (tmr_done) begin
          state_d   = RELEASE;
          hld_h_n_d = 1'b1;
        end
      end
      RELEASE: begin
        go_idle = 1'b1;
        tgt_dir = DIR_IN;
      end
      IDLE_IN, IDLE_OUT: begin
        // Hold wins over a same-cycle request; the request stays pending.
        if (hold_req) begin
          state_d     = HOLD;
          hld_h_n_d   = 1'b0;
          hold_ack_d  = 1'b1;
          req_ready_d = 1'b0;
        end else if (req_valid && (dir_req != cur_dir_q)) begin
          state_d     = TURN;
          dir_lat_d   = dir_req;
          oe_n_d      = 1'b1;
          inp_dis_d   = 1'b1;
          busy_d      = 1'b1;
          req_ready_d = 1'b0;
          tmr_load    = 1'b1;
        end
      end
      TURN: begin
        if (tmr_done) begin
          go_idle = 1'b1;
          tgt_dir = dir_lat_q;
        end
      end
      HOLD: begin
        if (!hold_req) begin
          hld_h_n_d   = 1'b1;
          hold_ack_d  = 1'b0;
          req_ready_d = 1'b1;
          state_d     = (cur_dir_q == DIR_IN) ? IDLE_IN : IDLE_OUT;
        end
      end
      default: state_d = PWRUP;
    endcase

    // Drive mode and the new buffer enable change on the same edge.
    if (go_idle) begin
      busy_d      = 1'b0;
      req_ready_d = 1'b1;
      cur_dir_d   = tgt_dir;
      if (tgt_dir == DIR_IN) begin
        state_d   = IDLE_IN;
        oe_n_d    = 1'b1;
        inp_dis_d = 1'b0;
        dm_d      = DM_IDLE_IN;
      end else begin
        state_d   = IDLE_OUT;
        inp_dis_d = 1'b1;
        oe_n_d    = 1'b0;
        dm_d      = DM_STRONG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PWRUP;
      enable_h_q  <= 1'b0;
      hld_h_n_q   <= 1'b0;
      oe_n_q      <= 1'b1;
      inp_dis_q   <= 1'b1;
      dm_q        <= DM_INPUT;
      cur_dir_q   <= DIR_IN;
      req_ready_q <= 1'b0;
      hold_ack_q  <= 1'b0;
      busy_q      <= 1'b1;
      dir_lat_q   <= DIR_IN;
    end else begin
      state_q     <= state_d;
      enable_h_q  <= enable_h_d;
      hld_h_n_q   <= hld_h_n_d;
      oe_n_q      <= oe_n_d;
      inp_dis_q   <= inp_dis_d;
      dm_q        <= dm_d;
      cur_dir_q   <= cur_dir_d;
      req_ready_q <= req_ready_d;
      hold_ack_q  <= hold_ack_d;
      busy_q      <= busy_d;
      dir_lat_q   <= dir_lat_d;
    end
  end

  assign pad_enable_h = enable_h_q;
  assign pad_hld_h_n  = hld_h_n_q;
  assign pad_oe_n     = oe_n_q;
  assign pad_inp_dis  = inp_dis_q;
  assign pad_dm       = dm_q;
  assign cur_dir      = cur_dir_q;
  assign req_ready    = req_ready_q;
  assign hold_ack     = hold_ack_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_pad_seq_ctrl.sv
// ============================================================================
// Module  : tb_gpio_pad_seq_ctrl
// Brief   : Directed self-checking bench for gpio_pad_seq_ctrl. Expected idle
//           input drive mode follows GPIO_PAD_SEQ_PULL_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpio_pad_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dir_req = 1'b1;
  logic       req_valid = 1'b0;
  logic       hold_req = 1'b0;
  logic       req_ready, hold_ack, cur_dir, busy;
  logic       pad_enable_h, pad_hld_h_n, pad_oe_n, pad_inp_dis;
  logic [2:0] pad_dm;

  int n_pass  = 0;
  int n_total = 0;

`ifdef GPIO_PAD_SEQ_PULL_EN
  localparam logic [2:0] C_DM_IN = 3'b010;
`else
  localparam logic [2:0] C_DM_IN = 3'b001;
`endif

  gpio_pad_seq_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .dir_req      (dir_req),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .hold_req     (hold_req),
    .hold_ack     (hold_ack),
    .cur_dir      (cur_dir),
    .busy         (busy),
    .pad_enable_h (pad_enable_h),
    .pad_hld_h_n  (pad_hld_h_n),
    .pad_oe_n     (pad_oe_n),
    .pad_inp_dis  (pad_inp_dis),
    .pad_dm       (pad_dm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Both buffers enabled at once must never be observed.
  always @(negedge clk) begin
    check("invariant_oe_inp", {7'd0, (pad_oe_n === 1'b0) && (pad_inp_dis === 1'b0)}, 8'd0);
  end

  initial begin
    // Reset values
    tick(3);
    check("rst_enable_h", {7'd0, pad_enable_h}, 8'd0);
    check("rst_hld_h_n", {7'd0, pad_hld_h_n}, 8'd0);
    check("rst_oe_n", {7'd0, pad_oe_n}, 8'd1);
    check("rst_inp_dis", {7'd0, pad_inp_dis}, 8'd1);
    check("rst_dm", {5'd0, pad_dm}, 8'h01);
    check("rst_cur_dir", {7'd0, cur_dir}, 8'd1);
    check("rst_req_ready", {7'd0, req_ready}, 8'd0);
    check("rst_hold_ack", {7'd0, hold_ack}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd1);

    // Power-up sequence
    rst = 1'b0;
    tick(1);
    check("pu_c1_enable_h", {7'd0, pad_enable_h}, 8'd1);
    check("pu_c1_hld_h_n", {7'd0, pad_hld_h_n}, 8'd0);
    tick(15);
    check("pu_c16_hld_h_n", {7'd0, pad_hld_h_n}, 8'd0);
    tick(1);
    check("pu_c17_hld_h_n", {7'd0, pad_hld_h_n}, 8'd1);
    check("pu_c17_inp_dis", {7'd0, pad_inp_dis}, 8'd1);
    check("pu_c17_req_ready", {7'd0, req_ready}, 8'd0);
    tick(1);
    check("pu_c18_inp_dis", {7'd0, pad_inp_dis}, 8'd0);
    check("pu_c18_req_ready", {7'd0, req_ready}, 8'd1);
    check("pu_c18_busy", {7'd0, busy}, 8'd0);
    check("pu_c18_dm", {5'd0, pad_dm}, {5'd0, C_DM_IN});

    // Direction change to output
    dir_req = 1'b0; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("turn_out_oe_n", {7'd0, pad_oe_n}, 8'd1);
      check("turn_out_inp_dis", {7'd0, pad_inp_dis}, 8'd1);
      check("turn_out_busy", {7'd0, busy}, 8'd1);
      check("turn_out_dm_kept", {5'd0, pad_dm}, {5'd0, C_DM_IN});
      check("turn_out_cur_dir", {7'd0, cur_dir}, 8'd1);
      tick(1);
    end
    check("idle_out_oe_n", {7'd0, pad_oe_n}, 8'd0);
    check("idle_out_inp_dis", {7'd0, pad_inp_dis}, 8'd1);
    check("idle_out_dm", {5'd0, pad_dm}, 8'h06);
    check("idle_out_cur_dir", {7'd0, cur_dir}, 8'd0);
    check("idle_out_busy", {7'd0, busy}, 8'd0);

    // Same-direction request is a no-op
    dir_req = 1'b0; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    check("same_busy", {7'd0, busy}, 8'd0);
    check("same_oe_n", {7'd0, pad_oe_n}, 8'd0);
    check("same_dm", {5'd0, pad_dm}, 8'h06);
    check("same_req_ready", {7'd0, req_ready}, 8'd1);
    check("same_cur_dir", {7'd0, cur_dir}, 8'd0);

    // Hold raised during TURN is deferred
    dir_req = 1'b1; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0; hold_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("turn_in_hold_ack", {7'd0, hold_ack}, 8'd0);
      check("turn_in_hld_h_n", {7'd0, pad_hld_h_n}, 8'd1);
      check("turn_in_dm_kept", {5'd0, pad_dm}, 8'h06);
      tick(1);
    end
    check("defer_idle_hold_ack", {7'd0, hold_ack}, 8'd0);
    check("defer_idle_inp_dis", {7'd0, pad_inp_dis}, 8'd0);
    check("defer_idle_cur_dir", {7'd0, cur_dir}, 8'd1);
    check("defer_idle_dm", {5'd0, pad_dm}, {5'd0, C_DM_IN});
    tick(1);
    check("hold_hld_h_n", {7'd0, pad_hld_h_n}, 8'd0);
    check("hold_ack", {7'd0, hold_ack}, 8'd1);
    check("hold_req_ready", {7'd0, req_ready}, 8'd0);
    check("hold_oe_n", {7'd0, pad_oe_n}, 8'd1);
    check("hold_inp_dis", {7'd0, pad_inp_dis}, 8'd0);
    hold_req = 1'b0;
    tick(1);
    check("unhold_hld_h_n", {7'd0, pad_hld_h_n}, 8'd1);
    check("unhold_ack", {7'd0, hold_ack}, 8'd0);
    check("unhold_req_ready", {7'd0, req_ready}, 8'd1);
    tick(1);
    check("unhold_cur_dir", {7'd0, cur_dir}, 8'd1);
    check("unhold_inp_dis", {7'd0, pad_inp_dis}, 8'd0);

    // Hold and request together: hold wins
    hold_req = 1'b1; dir_req = 1'b0; req_valid = 1'b1;
    tick(1);
    check("simul_hold_ack", {7'd0, hold_ack}, 8'd1);
    check("simul_cur_dir", {7'd0, cur_dir}, 8'd1);
    check("simul_oe_n", {7'd0, pad_oe_n}, 8'd1);
    tick(1);
    check("simul_still_hold", {7'd0, hold_ack}, 8'd1);
    check("simul_no_turn_busy", {7'd0, busy}, 8'd0);
    req_valid = 1'b0;

    // Reset while holding restarts power-up
    rst = 1'b1;
    tick(1);
    check("mrst_enable_h", {7'd0, pad_enable_h}, 8'd0);
    check("mrst_hld_h_n", {7'd0, pad_hld_h_n}, 8'd0);
    check("mrst_hold_ack", {7'd0, hold_ack}, 8'd0);
    check("mrst_busy", {7'd0, busy}, 8'd1);
    check("mrst_inp_dis", {7'd0, pad_inp_dis}, 8'd1);
    check("mrst_dm", {5'd0, pad_dm}, 8'h01);
    rst = 1'b0; hold_req = 1'b0; dir_req = 1'b1;
    tick(1);
    check("mpu_c1_enable_h", {7'd0, pad_enable_h}, 8'd1);
    tick(15);
    check("mpu_c16_hld_h_n", {7'd0, pad_hld_h_n}, 8'd0);
    tick(1);
    check("mpu_c17_hld_h_n", {7'd0, pad_hld_h_n}, 8'd1);
    tick(1);
    check("mpu_c18_req_ready", {7'd0, req_ready}, 8'd1);
    check("mpu_c18_dm", {5'd0, pad_dm}, {5'd0, C_DM_IN});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
